// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// buffers fetched words for decode. Optional macro FETCH_PERF_EN adds fetch/flush counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [31:0]   pc_r, pc_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s, count_pop_s;
  logic          ir_valid_r;
  logic          pop_s, fetch_s, flush_s;
  logic [31:0]   buf_ins_r [FIFO_DEPTH];
  logic [31:0]   buf_pc_r  [FIFO_DEPTH];
  logic [31:0]   shf_ins_s [FIFO_DEPTH];
  logic [31:0]   shf_pc_s  [FIFO_DEPTH];
  logic [31:0]   nxt_ins_s [FIFO_DEPTH];
  logic [31:0]   nxt_pc_s  [FIFO_DEPTH];
  logic          unused_ok_s;

  assign unused_ok_s = ^redirect_pc[1:0];

  // Entry 0 is always the head, so ir/ir_pc come straight from registers.
  assign imem_addr = {2'b00, pc_r[31:2]};
  assign pc        = pc_r;
  assign ir_valid  = ir_valid_r;
  assign ir        = buf_ins_r[0];
  assign ir_pc     = buf_pc_r[0];

  assign pop_s   = ir_valid_r & ir_ready;
  assign flush_s = redirect_valid & (state_r != HOLD);
  assign fetch_s = (state_r == RUN) & ~halt & ~redirect_valid &
                   ((count_r < CW'(FIFO_DEPTH)) | pop_s);

  // Next-state and PC selection; redirect outranks sequential fetch.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      HOLD:    state_nxt_s = RUN;
      RUN:     state_nxt_s = (halt & ~redirect_valid) ? HALTED : RUN;
      HALTED:  state_nxt_s = (~halt | redirect_valid) ? RUN : HALTED;
      default: state_nxt_s = HOLD;
    endcase
    if (redirect_valid) begin
      pc_nxt_s = {redirect_pc[31:2], 2'b00};
    end else if (fetch_s) begin
      pc_nxt_s = pc_r + 32'd4;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Buffer update: shift on pop, then write the new word behind the survivors.
  always_comb begin
    count_pop_s = count_r - {{(CW-1){1'b0}}, pop_s};
    count_nxt_s = count_r;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (pop_s && (i < FIFO_DEPTH - 1)) begin
        shf_ins_s[i] = buf_ins_r[i+1];
        shf_pc_s[i]  = buf_pc_r[i+1];
      end else if (pop_s) begin
        shf_ins_s[i] = 32'h0000_0000;
        shf_pc_s[i]  = 32'h0000_0000;
      end else begin
        shf_ins_s[i] = buf_ins_r[i];
        shf_pc_s[i]  = buf_pc_r[i];
      end
      nxt_ins_s[i] = (fetch_s && (CW'(i) == count_pop_s)) ? imem_data : shf_ins_s[i];
      nxt_pc_s[i]  = (fetch_s && (CW'(i) == count_pop_s)) ? pc_r      : shf_pc_s[i];
      if (flush_s) begin
        nxt_ins_s[i] = 32'h0000_0000;
        nxt_pc_s[i]  = 32'h0000_0000;
      end else begin
        nxt_ins_s[i] = nxt_ins_s[i];
        nxt_pc_s[i]  = nxt_pc_s[i];
      end
    end
    if (flush_s) begin
      count_nxt_s = {CW{1'b0}};
    end else if (fetch_s) begin
      count_nxt_s = count_pop_s + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_nxt_s = count_pop_s;
    end
  end

  // State, PC and buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= HOLD;
      pc_r       <= RESET_PC;
      count_r    <= {CW{1'b0}};
      ir_valid_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_ins_r[i] <= 32'h0000_0000;
        buf_pc_r[i]  <= 32'h0000_0000;
      end
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      count_r    <= count_nxt_s;
      ir_valid_r <= (count_nxt_s != {CW{1'b0}});
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_ins_r[i] <= nxt_ins_s[i];
        buf_pc_r[i]  <= nxt_pc_s[i];
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_r;
  logic [15:0] flush_count_r;
  assign fetch_count = fetch_count_r;
  assign flush_count = flush_count_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_r <= 32'd0;
      flush_count_r <= 16'd0;
    end else begin
      fetch_count_r <= fetch_count_r + {31'd0, fetch_s};
      flush_count_r <= flush_count_r + {15'd0, flush_s};
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a queue-based model;
// a second instance checks PC wrap-around from RESET_PC = 32'hFFFF_FFF8.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data, redirect_pc, ir, ir_pc, pc;
  logic        redirect_valid, halt, ir_valid, ir_ready;
  logic [31:0] imem_addr_w, imem_data_w, ir_w, ir_pc_w, pc_w;
  logic        ir_valid_w;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, fetch_count_w;
  logic [15:0] flush_count, flush_count_w;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_data   = memf(imem_addr);
  assign imem_data_w = memf(imem_addr_w);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc), .pc(pc)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000), .halt(1'b0),
    .ir_valid(ir_valid_w), .ir_ready(1'b1), .ir(ir_w), .ir_pc(ir_pc_w), .pc(pc_w)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count_w), .flush_count(flush_count_w)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: a queue of {pc, word} plus a fetch pointer and mode.
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef enum int { M_HOLD, M_RUN, M_HALT } mode_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  mode_t       mst;
  logic [31:0] m_fetches;
  logic [15:0] m_flushes;

  task automatic model_reset();
    mq.delete();
    mpc       = 32'h0000_0000;
    mst       = M_HOLD;
    m_fetches = 32'd0;
    m_flushes = 16'd0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rp, input logic h, input logic rdy);
    bit   pop, fetch;
    ent_t e;
    pop   = (mq.size() != 0) && rdy;
    fetch = (mst == M_RUN) && !h && !rv && ((mq.size() < DEPTH) || pop);
    e.pc  = mpc;
    e.ins = memf(mpc / 32'd4);
    if (rv && mst != M_HOLD) begin
      mq.delete();
      m_flushes = m_flushes + 16'd1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (fetch) mq.push_back(e);
    end
    if (fetch) m_fetches = m_fetches + 32'd1;
    if (rv) mpc = rp & 32'hFFFF_FFFC;
    else if (fetch) mpc = mpc + 32'd4;
    case (mst)
      M_HOLD:  mst = M_RUN;
      M_RUN:   if (h && !rv) mst = M_HALT;
      M_HALT:  if (!h || rv) mst = M_RUN;
      default: mst = M_HOLD;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, mq.size() != 0});
    check({tag, ".ir"}, ir, (mq.size() != 0) ? mq[0].ins : 32'h0);
    check({tag, ".ir_pc"}, ir_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
    check({tag, ".pc"}, pc, mpc);
    check({tag, ".imem_addr"}, imem_addr, mpc / 32'd4);
`ifdef FETCH_PERF_EN
    check({tag, ".fetch_count"}, fetch_count, m_fetches);
    check({tag, ".flush_count"}, {16'd0, flush_count}, {16'd0, m_flushes});
`endif
  endtask

  task automatic cycle(input logic rv, input logic [31:0] rp, input logic h, input logic rdy, input string tag);
    redirect_valid = rv;
    redirect_pc    = rp;
    halt           = h;
    ir_ready       = rdy;
    model_step(rv, rp, h, rdy);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    ir_ready = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] held_pc;
  logic        hlev;

  initial begin
    // Streaming from reset, plus wrap-around on the second instance.
    do_reset();
    for (int j = 1; j <= 6; j++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, "stream");
      if (j <= 4) check("stream.addr", imem_addr, j - 1);
      if (j >= 2 && j <= 5) begin
        check("stream.ir", ir, memf(j - 2));
        check("stream.ir_pc", ir_pc, (j - 2) * 4);
      end
      if (j == 2) check("wrap.ir_pc0", ir_pc_w, 32'hFFFF_FFF8);
      if (j == 3) check("wrap.ir_pc1", ir_pc_w, 32'hFFFF_FFFC);
      if (j == 4) check("wrap.ir_pc2", ir_pc_w, 32'h0000_0000);
      if (j == 3) check("wrap.addr", imem_addr_w, 32'h0000_0000);
    end

    // Backpressure fills the buffer, then drains in order.
    do_reset();
    for (int j = 0; j < 6; j++) cycle(1'b0, 32'h0, 1'b0, 1'b0, "fill");
    check("fill.pc", pc, 32'h8);
    check("fill.ir", ir, memf(0));
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, "drain");
      check("drain.ir_pc", ir_pc, k * 4);
    end

    // Redirect mid-stream to a misaligned target.
    for (int j = 0; j < 3; j++) cycle(1'b0, 32'h0, 1'b0, 1'b1, "pre_rd");
    cycle(1'b1, 32'h0000_0027, 1'b0, 1'b1, "redirect");
    check("redirect.valid", {31'd0, ir_valid}, 32'd0);
    check("redirect.pc", pc, 32'h24);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, "post_rd");
    check("post_rd.ir_pc", ir_pc, 32'h24);

    // Halt with a full buffer: drain without fetching, then resume.
    for (int j = 0; j < 4; j++) cycle(1'b0, 32'h0, 1'b0, 1'b0, "pre_halt");
    held_pc = mpc;
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1, "halt");
      check("halt.pc", pc, held_pc);
    end
    check("halt.empty", {31'd0, ir_valid}, 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, "resume");
    cycle(1'b0, 32'h0, 1'b0, 1'b1, "resume");
    check("resume.ir_pc", ir_pc, held_pc);

    // Random traffic.
    hlev = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 9) == 0) hlev = ~hlev;
      cycle(($urandom_range(0, 15) == 0), $urandom, hlev, ($urandom_range(0, 3) != 0), "rand");
    end

    // Reset while full and redirecting: asynchronous clear.
    for (int j = 0; j < 4; j++) cycle(1'b0, 32'h0, 1'b0, 1'b0, "pre_arst");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1000;
    reset = 1'b1;
    #1;
    check("arst.valid", {31'd0, ir_valid}, 32'd0);
    check("arst.pc", pc, 32'h0);
    check("arst.ir", ir, 32'h0);
`ifdef FETCH_PERF_EN
    check("arst.fetch_count", fetch_count, 32'd0);
    check("arst.flush_count", {16'd0, flush_count}, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    redirect_valid = 1'b0;
    for (int j = 0; j < 5; j++) cycle(1'b0, 32'h0, 1'b0, 1'b1, "post_arst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
